// File: rtl/vend_txn_if.sv
`default_nettype none
// ============================================================================
//  Module   : vend_txn_if
//  Purpose  : Bus bundle between the vending front end / peripherals and the
//             transaction sequencer. Carries the coin, selection and cancel
//             strobes, the external price/stock lookup, the dispenser and
//             coin-hopper handshakes, and the display/status outputs.
//  Modports : master - front end / peripherals (drives strobes, price, acks)
//             slave  - vend_txn_sequencer
//  Revision : 1.0 - initial release
// ============================================================================
interface vend_txn_if #(
    parameter int CW = 10
);
    logic          coin_valid;
    logic [CW-1:0] coin_value;
    logic          sel_valid;
    logic [3:0]    sel_code;
    logic          cancel;
    logic [3:0]    price_idx;
    logic [CW-1:0] price_in;
    logic [8:0]    stock_empty;
    logic          dispense_valid;
    logic [3:0]    dispense_code;
    logic          dispense_ack;
    logic          coin_out_valid;
    logic [1:0]    coin_out_sel;
    logic          coin_out_ack;
    logic          coin_reject;
    logic [CW-1:0] credit;
    logic [CW-1:0] disp_value;
    logic          disp_neg;
    logic [2:0]    status;

    modport master (
        output coin_valid, coin_value, sel_valid, sel_code, cancel,
               price_in, stock_empty, dispense_ack, coin_out_ack,
        input  price_idx, dispense_valid, dispense_code, coin_out_valid,
               coin_out_sel, coin_reject, credit, disp_value, disp_neg, status
    );

    modport slave (
        input  coin_valid, coin_value, sel_valid, sel_code, cancel,
               price_in, stock_empty, dispense_ack, coin_out_ack,
        output price_idx, dispense_valid, dispense_code, coin_out_valid,
               coin_out_sel, coin_reject, credit, disp_value, disp_neg, status
    );
endinterface
`default_nettype wire

// File: rtl/vend_txn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vend_txn_sequencer
//  Purpose  : Transaction controller for a 9-slot (A1..C3) vending machine.
//             Accumulates credit, checks price/stock of a selection, drives
//             the dispense handshake and pays change coin-by-coin
//             (100/25/10/5 cents, largest first).
//  Ports    : clk  - system clock
//             rst  - asynchronous active-high reset
//             bus  - vend_txn_if.slave (strobes, lookup, handshakes, display)
//  Options  : VEND_INACTIVITY_TIMEOUT_EN - when defined, credit left idle for
//             TIMEOUT_CYCLES clocks is refunded with status TIMEOUT.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_txn_sequencer #(
    parameter int MAX_CREDIT = 500,
    parameter int CW         = 10
`ifdef VEND_INACTIVITY_TIMEOUT_EN
    , parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    vend_txn_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CREDIT   = 3'd1,
        LOOKUP   = 3'd2,
        DISPENSE = 3'd3,
        PAYOUT   = 3'd4
    } state_t;

    localparam logic [2:0]  C_ST_OK      = 3'd0;
    localparam logic [2:0]  C_ST_PRICE   = 3'd1;
    localparam logic [2:0]  C_ST_SHORT   = 3'd2;
    localparam logic [2:0]  C_ST_OOS     = 3'd3;
    localparam logic [2:0]  C_ST_TIMEOUT = 3'd4;
    localparam logic [CW:0] C_MAX_CREDIT = MAX_CREDIT[CW:0];

    state_t        r_state;
    logic [CW-1:0] r_credit;
    logic [CW-1:0] r_change_rem;
    logic [CW-1:0] r_disp_value;
    logic          r_disp_neg;
    logic [2:0]    r_status;
    logic [3:0]    r_price_idx;
    logic [3:0]    r_dispense_code;
    logic          r_dispense_valid;
    logic          r_coin_out_valid;
    logic [1:0]    r_coin_out_sel;
    logic          r_coin_reject;

    logic [CW:0]   w_sum;
    logic          w_open;
    logic          w_coin_ok;
    logic          w_coin_take;
    logic          w_sel_ok;
    logic          w_timeout;
    logic          w_cancel_now;
    logic [1:0]    w_next_sel;
    logic [CW-1:0] w_coin_cents;

    // Credit sum one bit wider so an overflow cannot wrap under the limit.
    assign w_sum     = {1'b0, r_credit} + {1'b0, bus.coin_value};
    assign w_open    = (r_state == IDLE) || (r_state == CREDIT);
    assign w_coin_ok = (bus.coin_value != '0) &&
                       ((bus.coin_value % CW'(5)) == '0) &&
                       (w_sum <= C_MAX_CREDIT);
    assign w_sel_ok  = bus.sel_valid && (bus.sel_code <= 4'd8);

`ifdef VEND_INACTIVITY_TIMEOUT_EN
    logic [31:0] r_idle_cnt;

    assign w_timeout = (r_state == CREDIT) && (r_idle_cnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if ((r_state != CREDIT) || w_timeout || w_coin_take || w_sel_ok) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // A timeout behaves exactly like a user cancel.
    assign w_cancel_now = bus.cancel || w_timeout;
    // Any cancel or selection strobe in the same cycle wins over a coin.
    assign w_coin_take  = bus.coin_valid && w_open && w_coin_ok &&
                          !w_cancel_now && !bus.sel_valid;

    always_comb begin
        w_next_sel = 2'b00;
        if (r_change_rem >= CW'(100))     w_next_sel = 2'b11;
        else if (r_change_rem >= CW'(25)) w_next_sel = 2'b10;
        else if (r_change_rem >= CW'(10)) w_next_sel = 2'b01;
    end

    always_comb begin
        case (r_coin_out_sel)
            2'b00:   w_coin_cents = CW'(5);
            2'b01:   w_coin_cents = CW'(10);
            2'b10:   w_coin_cents = CW'(25);
            default: w_coin_cents = CW'(100);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_credit         <= '0;
            r_change_rem     <= '0;
            r_disp_value     <= '0;
            r_disp_neg       <= 1'b0;
            r_status         <= C_ST_OK;
            r_price_idx      <= '0;
            r_dispense_code  <= '0;
            r_dispense_valid <= 1'b0;
            r_coin_out_valid <= 1'b0;
            r_coin_out_sel   <= '0;
            r_coin_reject    <= 1'b0;
        end else begin
            r_coin_reject <= bus.coin_valid && !w_coin_take;
            case (r_state)
                IDLE, CREDIT: begin
                    if (w_cancel_now) begin
                        if (r_state == CREDIT) begin
                            r_change_rem <= r_credit;
                            r_credit     <= '0;
                            r_disp_value <= r_credit;
                            r_disp_neg   <= 1'b0;
                            if (w_timeout) r_status <= C_ST_TIMEOUT;
                            r_state      <= PAYOUT;
                        end
                    end else if (w_sel_ok) begin
                        r_price_idx <= bus.sel_code;
                        r_state     <= LOOKUP;
                    end else if (w_coin_take) begin
                        r_credit     <= w_sum[CW-1:0];
                        r_disp_value <= w_sum[CW-1:0];
                        r_disp_neg   <= 1'b0;
                        r_status     <= C_ST_OK;
                        r_state      <= CREDIT;
                    end
                end
                LOOKUP: begin
                    if (bus.stock_empty[r_price_idx] || (bus.price_in == '0)) begin
                        r_status <= C_ST_OOS;
                        r_state  <= (r_credit == '0) ? IDLE : CREDIT;
                    end else if (r_credit == '0) begin
                        r_status     <= C_ST_PRICE;
                        r_disp_value <= bus.price_in;
                        r_disp_neg   <= 1'b0;
                        r_state      <= IDLE;
                    end else if (r_credit < bus.price_in) begin
                        r_status     <= C_ST_SHORT;
                        r_disp_value <= bus.price_in - r_credit;
                        r_disp_neg   <= 1'b1;
                        r_state      <= CREDIT;
                    end else begin
                        r_change_rem     <= r_credit - bus.price_in;
                        r_disp_value     <= r_credit - bus.price_in;
                        r_disp_neg       <= 1'b0;
                        r_status         <= C_ST_OK;
                        r_credit         <= '0;
                        r_dispense_code  <= r_price_idx;
                        r_dispense_valid <= 1'b1;
                        r_state          <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (bus.dispense_ack) begin
                        r_dispense_valid <= 1'b0;
                        r_state          <= (r_change_rem != '0) ? PAYOUT : IDLE;
                    end
                end
                PAYOUT: begin
                    if (r_coin_out_valid) begin
                        if (bus.coin_out_ack) begin
                            r_change_rem     <= r_change_rem - w_coin_cents;
                            r_disp_value     <= r_change_rem - w_coin_cents;
                            r_coin_out_valid <= 1'b0;
                        end
                    end else if (r_change_rem < CW'(5)) begin
                        // A sub-5c residue (odd external price) cannot be paid
                        // out by the hopper and is forfeited.
                        r_change_rem <= '0;
                        r_disp_value <= '0;
                        r_state      <= IDLE;
                    end else begin
                        r_coin_out_sel   <= w_next_sel;
                        r_coin_out_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.price_idx      = r_price_idx;
    assign bus.dispense_valid = r_dispense_valid;
    assign bus.dispense_code  = r_dispense_code;
    assign bus.coin_out_valid = r_coin_out_valid;
    assign bus.coin_out_sel   = r_coin_out_sel;
    assign bus.coin_reject    = r_coin_reject;
    assign bus.credit         = r_credit;
    assign bus.disp_value     = r_disp_value;
    assign bus.disp_neg       = r_disp_neg;
    assign bus.status         = r_status;
endmodule
`default_nettype wire
